// File: rtl/dp_mac_seq.sv
// Sequential signed dot-product engine: streams element/weight pairs through an
// external shared multiplier and accumulates the products into a wide sum.
module dp_mac_seq #(
  parameter int SWIDTH = 64,
  parameter int LWIDTH = 7,
  parameter int CNTW   = 10,
  localparam int AWIDTH = SWIDTH + LWIDTH + CNTW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [CNTW-1:0]            len,
  output logic                       busy,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SWIDTH-1:0]          indataS,
  input  logic [LWIDTH-1:0]          indataL,
  output logic [SWIDTH-1:0]          mul_a,
  output logic [LWIDTH-1:0]          mul_b,
  input  logic [SWIDTH+LWIDTH-1:0]   mul_p,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [AWIDTH-1:0]          outdata
);

  localparam int PWIDTH = SWIDTH + LWIDTH;
  localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t                  state, state_nxt;
  logic [CNTW-1:0]         len_q;
  logic [CNTW-1:0]         count;
  logic [PWIDTH-1:0]       prod;
  logic                    prod_vld;
  logic [AWIDTH-1:0]       acc;
  logic                    accept;
  logic                    last_beat;

  assign in_ready  = (state == RUN) && (count < len_q);
  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (count == (len_q - CNT_ONE));

  // Multiplier operands are gated to zero unless a beat can be taken.
  assign mul_a = in_ready ? indataS : {SWIDTH{1'b0}};
  assign mul_b = in_ready ? indataL : {LWIDTH{1'b0}};

  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign outdata   = acc;

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len == CNT_ZERO) ? DONE : RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (last_beat) begin
          state_nxt = DRAIN;
        end else begin
          state_nxt = RUN;
        end
      end
      DRAIN: state_nxt = DONE;
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, beat counter, product pipeline register and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len_q    <= CNT_ZERO;
      count    <= CNT_ZERO;
      prod     <= {PWIDTH{1'b0}};
      prod_vld <= 1'b0;
      acc      <= {AWIDTH{1'b0}};
    end else begin
      state    <= state_nxt;
      prod_vld <= accept;
      if (accept) begin
        prod <= mul_p;
      end
      if ((state == IDLE) && start) begin
        len_q <= len;
        count <= CNT_ZERO;
        acc   <= {AWIDTH{1'b0}};
      end else begin
        if (accept) begin
          count <= count + CNT_ONE;
        end
        // Product is one cycle behind acceptance; DRAIN absorbs the last one.
        if (prod_vld) begin
          acc <= acc + {{CNTW{prod[PWIDTH-1]}}, prod};
        end
      end
    end
  end

endmodule

// File: tb/tb_dp_mac_seq.sv
// Randomized self-checking bench for dp_mac_seq against an arithmetic reference
// of the dot product and its cycle-level handshake timing.
module tb_dp_mac_seq;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [9:0]          len;
  logic                busy;
  logic                in_valid;
  logic                in_ready;
  logic signed [63:0]  indataS;
  logic signed [6:0]   indataL;
  logic signed [63:0]  mul_a;
  logic signed [6:0]   mul_b;
  logic signed [70:0]  mul_p;
  logic                out_valid;
  logic                out_ready;
  logic signed [80:0]  outdata;

  int tests_run = 0;
  int tests_failed = 0;

  logic signed [63:0] sa[$];
  logic signed [6:0]  sl[$];

  always #5 clk = ~clk;

  assign mul_p = mul_a * mul_b;

  dp_mac_seq dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .indataS(indataS), .indataL(indataL),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .outdata(outdata)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_pair(input logic signed [63:0] s, input logic signed [6:0] l);
    sa.push_back(s);
    sl.push_back(l);
  endtask

  // One complete operation; bubbles of bmin..bmax cycles follow each accepted beat,
  // out_ready stays low for 'hold' DONE cycles, optional random start pulses.
  task automatic run_op(input int n, input int bmin, input int bmax, input int hold, input bit rand_start);
    logic signed [80:0] exp_sum;
    logic signed [63:0] exp_a;
    logic signed [6:0]  exp_b;
    int idx, cyc, last_acc, bub, hold_left, limit;
    bit fin, rdy_exp, ov_exp;
    exp_sum = '0;
    for (int i = 0; i < n; i++) exp_sum += sa[i] * sl[i];
    idx = 0; last_acc = 0; bub = 0; hold_left = hold; fin = 1'b0;
    limit = n * (bmax + 1) + hold + 10;
    @(posedge clk); #1;
    start = 1'b1; len = 10'(n); in_valid = 1'b0; out_ready = (hold == 0);
    @(negedge clk);
    check_val("idle_ready", {127'd0, in_ready}, 128'd0);
    cyc = 1;
    while (!fin && cyc <= limit) begin
      @(posedge clk); #1;
      start = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = (hold_left == 0);
      if (idx < n && bub == 0) begin
        in_valid = 1'b1; indataS = sa[idx]; indataL = sl[idx];
      end else begin
        in_valid = 1'b0; indataS = {$urandom, $urandom}; indataL = 7'($urandom);
        if (bub > 0) bub--;
      end
      @(negedge clk);
      rdy_exp = (n != 0) && (idx < n);
      exp_a = rdy_exp ? indataS : 64'sd0;
      exp_b = rdy_exp ? indataL : 7'sd0;
      check_val("in_ready", {127'd0, in_ready}, {127'd0, rdy_exp});
      check_val("mul_a", mul_a, exp_a);
      check_val("mul_b", mul_b, exp_b);
      check_val("busy", {127'd0, busy}, 128'd1);
      if (rdy_exp && in_valid) begin
        idx++;
        last_acc = cyc;
        bub = $urandom_range(bmin, bmax);
      end
      ov_exp = (idx == n) && (cyc >= ((n == 0) ? 1 : last_acc + 2));
      check_val("out_valid", {127'd0, out_valid}, {127'd0, ov_exp});
      if (ov_exp) begin
        check_val("outdata", outdata, exp_sum);
        if (out_ready) fin = 1'b1;
        else hold_left--;
      end
      cyc++;
    end
    if (!fin) check_val("timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check_val("post_busy", {127'd0, busy}, 128'd0);
    check_val("post_ovalid", {127'd0, out_valid}, 128'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = 10'd0; in_valid = 1'b0; out_ready = 1'b0;
    indataS = 64'sd0; indataL = 7'sd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_busy", {127'd0, busy}, 128'd0);
    check_val("rst_ready", {127'd0, in_ready}, 128'd0);
    check_val("rst_ovalid", {127'd0, out_valid}, 128'd0);
    check_val("rst_outdata", outdata, 128'd0);

    // Small worked example: 10 - 12 - 7
    sa.delete(); sl.delete();
    push_pair(64'sd5, 7'sd2); push_pair(-64'sd4, 7'sd3); push_pair(64'sd7, -7'sd1);
    run_op(3, 0, 0, 0, 1'b0);

    // Empty vector goes straight to DONE
    sa.delete(); sl.delete();
    run_op(0, 0, 0, 0, 1'b0);

    // Extreme magnitudes with three-cycle bubbles
    sa.delete(); sl.delete();
    push_pair(64'h7fff_ffff_ffff_ffff, -7'sd64); push_pair(64'h8000_0000_0000_0000, -7'sd64);
    run_op(2, 3, 3, 0, 1'b0);

    // Result held in DONE while consumer stalls; start pulses ignored
    sa.delete(); sl.delete();
    for (int i = 0; i < 4; i++) push_pair({$urandom, $urandom}, 7'($urandom));
    run_op(4, 0, 1, 10, 1'b1);

    // Reset in the middle of a len=5 operation
    sa.delete(); sl.delete();
    @(posedge clk); #1 start = 1'b1; len = 10'd5;
    @(posedge clk); #1 start = 1'b0; in_valid = 1'b1; indataS = 64'sd11; indataL = 7'sd5;
    @(posedge clk); #1 indataS = -64'sd6; indataL = 7'sd9;
    @(posedge clk); #1 rst = 1'b1; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check_val("mid_rst_busy", {127'd0, busy}, 128'd0);
    check_val("mid_rst_ready", {127'd0, in_ready}, 128'd0);
    check_val("mid_rst_ovalid", {127'd0, out_valid}, 128'd0);
    check_val("mid_rst_outdata", outdata, 128'd0);
    push_pair(64'sd3, 7'sd3);
    run_op(1, 0, 0, 0, 1'b0);

    // Maximum length, unit operands
    sa.delete(); sl.delete();
    for (int i = 0; i < 1023; i++) push_pair(64'sd1, 7'sd1);
    run_op(1023, 0, 0, 0, 1'b0);

    // Random operations
    for (int t = 0; t < 20; t++) begin
      int n;
      sa.delete(); sl.delete();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) push_pair({$urandom, $urandom}, 7'($urandom));
      run_op(n, 0, 2, $urandom_range(0, 3), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
